// File: rtl/bcd_to_bin_loader_pkg.sv
// Shared types and helpers for the BCD -> binary loader.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} b2b_state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // acc*10 + digit built from shifts. The width is fixed at 64 bits so one
  // helper serves any result width; callers truncate to their own width,
  // which is exact because the low bits of a product depend only on the
  // low bits of its operands.
  function automatic logic [63:0] mul10_add(input logic [63:0] acc,
                                            input bcd_digit_t  digit);
    return (acc << 3) + (acc << 1) + {60'd0, digit};
  endfunction

endpackage

// File: rtl/bcd_to_bin_loader_if.sv
// Request/result handshake bundle for bcd_to_bin_loader.
// slave = converter side, master = producer/consumer side.
interface bcd_to_bin_loader_if #(
  parameter int N_DIGITS = 6,
  parameter int BIN_W    = 20
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4*N_DIGITS-1:0]   bcd_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [BIN_W-1:0]        bin_out;
  logic                    err;

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err
  );

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err
  );
endinterface

// File: rtl/bcd_to_bin_loader_mac10.sv
// One decimal step: acc*10 + digit, plus a flag for a non-decimal digit.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int W = 20
) (
  input  logic [W-1:0] acc_i,
  input  bcd_digit_t   digit_i,
  output logic [W-1:0] acc_o,
  output logic         bad_o
);

  assign acc_o = W'(mul10_add(64'(acc_i), digit_i));
  assign bad_o = (digit_i > BCD_MAX);

endmodule

// File: rtl/bcd_to_bin_loader.sv
// Sequential BCD -> binary converter, one digit per clock, MSD first.
// Optional build macro DIGIT_CHECK_EN: flag digits >9 (err=1, bin_out=0).
module bcd_to_bin_loader
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int BIN_W    = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_to_bin_loader_if.slave   bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

`ifdef DIGIT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  b2b_state_t            state_q, state_d;
  logic [4*N_DIGITS-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BIN_W-1:0]      acc_q, acc_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic                  err_q, err_d;
  logic                  flag_q, flag_d;

  bcd_digit_t            digit;
  logic [BIN_W-1:0]      mac_acc;
  logic                  mac_bad;
  logic                  bad_any;

  assign digit = cap_q[{idx_q, 2'b00} +: 4];

  bcd_mac10 #(.W(BIN_W)) u_mac (
    .acc_i   (acc_q),
    .digit_i (digit),
    .acc_o   (mac_acc),
    .bad_o   (mac_bad)
  );

  // Sticky bad-digit indication including the digit being accumulated now;
  // forced low when the check is compiled out.
  assign bad_any = CHK & (flag_q | mac_bad);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state and datapath update for IDLE -> ACCUM -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    err_d   = err_q;
    flag_d  = flag_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cap_d   = bus.bcd_in;
          acc_d   = '0;
          idx_d   = IDX_W'(N_DIGITS - 1);
          flag_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d  = mac_acc;
        flag_d = bad_any;
        idx_d  = idx_q - IDX_W'(1);
        // Digit 0 is being folded in: publish the result this edge.
        if (idx_q == '0) begin
          bin_d   = bad_any ? '0 : mac_acc;
          err_d   = bad_any;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bin_out   = bin_q;
  assign bus.err       = err_q;

endmodule
